// File: rtl/alu_add8_seq.sv
// Sequences an 8-bit add through a 4-bit adder, low nibble then high nibble with the carry chained.
// Optional subtract support is enabled by defining ALU_ADD8_SUB_EN (adds the `sub` port).
module alu_add8_seq #(
    parameter int READY_TIMEOUT = 255,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
`ifdef ALU_ADD8_SUB_EN
    input  logic       sub,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cout,
    output logic       zero,
    output logic       ovf,
    output logic       err,
    output logic       add_en,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    input  logic       add_ready
);

    localparam int TW = $clog2(READY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(READY_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LO_REQ = 3'd1,
        S_GAP    = 3'd2,
        S_HI_REQ = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic logic [7:0] f_b_eff(input logic [7:0] b_v, input logic sub_v);
        return sub_v ? ~b_v : b_v;
    endfunction

    function automatic logic f_c_eff(input logic c_v, input logic sub_v);
        return sub_v ? 1'b1 : c_v;
    endfunction

    function automatic logic f_ovf(input logic a7, input logic b7, input logic r7);
        return (a7 == b7) && (r7 != a7);
    endfunction

    state_e          state_q, state_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic            c_q, c_d, sub_q, sub_d;
    logic [3:0]      res_lo_q, res_lo_d;
    logic            c_mid_q, c_mid_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]      result_q, result_d;
    logic            cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic            add_en_q, add_en_d, add_cin_q, add_cin_d;
    logic [3:0]      add_a_q, add_a_d, add_b_q, add_b_d;

    logic            sub_in_s;
    logic [7:0]      in_b_eff_s, b_eff_s;
    logic            in_c_eff_s, c_eff_s;
    logic [7:0]      hi_result_s;

`ifdef ALU_ADD8_SUB_EN
    assign sub_in_s = sub;
`else
    assign sub_in_s = 1'b0;
`endif

    assign in_b_eff_s  = f_b_eff(b, sub_in_s);
    assign in_c_eff_s  = f_c_eff(cin, sub_in_s);
    assign b_eff_s     = f_b_eff(b_q, sub_q);
    assign c_eff_s     = f_c_eff(c_q, sub_q);
    assign hi_result_s = {add_sum, res_lo_q};

    // Next-state and next-output logic for the two-pass sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        sub_d     = sub_q;
        res_lo_d  = res_lo_q;
        c_mid_d   = c_mid_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        add_en_d  = add_en_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    c_d       = cin;
                    sub_d     = sub_in_s;
                    to_cnt_d  = '0;
                    busy_d    = 1'b1;
                    add_en_d  = 1'b1;
                    add_a_d   = a[3:0];
                    add_b_d   = in_b_eff_s[3:0];
                    add_cin_d = in_c_eff_s;
                    state_d   = S_LO_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO_REQ: begin
                add_a_d   = a_q[3:0];
                add_b_d   = b_eff_s[3:0];
                add_cin_d = c_eff_s;
                if (add_ready) begin
                    res_lo_d  = add_sum;
                    c_mid_d   = add_cout;
                    gap_cnt_d = '0;
                    add_en_d  = 1'b0;
                    state_d   = S_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    add_en_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    result_d = 8'h00;
                    cout_d   = 1'b0;
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    to_cnt_d  = '0;
                    add_en_d  = 1'b1;
                    add_a_d   = a_q[7:4];
                    add_b_d   = b_eff_s[7:4];
                    add_cin_d = c_mid_q;
                    state_d   = S_HI_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_HI_REQ: begin
                if (add_ready) begin
                    add_en_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                    result_d = hi_result_s;
                    cout_d   = add_cout;
                    zero_d   = (hi_result_s == 8'h00);
                    ovf_d    = f_ovf(a_q[7], b_eff_s[7], add_sum[3]);
                    state_d  = S_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    add_en_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    result_d = 8'h00;
                    cout_d   = 1'b0;
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                add_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops add_en without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            c_q       <= 1'b0;
            sub_q     <= 1'b0;
            res_lo_q  <= 4'h0;
            c_mid_q   <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= 8'h00;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            add_en_q  <= 1'b0;
            add_a_q   <= 4'h0;
            add_b_q   <= 4'h0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            sub_q     <= sub_d;
            res_lo_q  <= res_lo_d;
            c_mid_q   <= c_mid_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            add_en_q  <= add_en_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero    = zero_q;
    assign ovf     = ovf_q;
    assign err     = err_q;
    assign add_en  = add_en_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;

endmodule
